// File: rtl/sram_arb.sv
// Two-port round-robin arbiter into sram_ifc; issue is 1 cycle after grant, read return BASE_LAT+OUT_REG cycles after grant.
// Backpressure: gnt is the combinational ready per port; requesters hold fields until granted, rvalid cannot be stalled.
module sram_arb #(
    parameter int OUT_REG    = 0,
    parameter int BASE_LAT   = 3,
    parameter int FIXED_PRIO = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [13:0] addr0,
    input  logic [13:0] addr1,
    input  logic [2:0]  conf0,
    input  logic [2:0]  conf1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        csb,
    output logic        web,
    output logic [13:0] addr,
    output logic [2:0]  conf,
    output logic [31:0] d_fabric_in,
    output logic        out_reg,
    input  logic [31:0] d_fabric_out
);

    localparam int LAT = BASE_LAT + OUT_REG;

    logic           rr_ptr;     // port that wins the next contended cycle
    logic           take0;
    logic           take1;
    logic           push_rd;
    logic [LAT-1:0] tag_vld;
    logic [LAT-1:0] tag_port;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (FIXED_PRIO != 0) begin
                gnt0 = req0;
                gnt1 = req1 & ~req0;
            end else if (req0 && req1) begin
                gnt0 = ~rr_ptr;
                gnt1 = rr_ptr;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    assign take0   = req0 & gnt0;
    assign take1   = req1 & gnt1;
    assign push_rd = (take0 & ~we0) | (take1 & ~we1);

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr      <= 1'b0;
            csb         <= 1'b1;
            web         <= 1'b1;
            addr        <= '0;
            conf        <= '0;
            d_fabric_in <= '0;
        end else if (take0 || take1) begin
            rr_ptr      <= take0;
            csb         <= 1'b0;
            web         <= take1 ? ~we1 : ~we0;
            addr        <= take1 ? addr1 : addr0;
            conf        <= take1 ? conf1 : conf0;
            d_fabric_in <= take1 ? wdata1 : wdata0;
        end else begin
            csb <= 1'b1;
            web <= 1'b1;
        end
    end

    // Tag pipeline mirrors the fixed sram_ifc/SRAM read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld  <= '0;
            tag_port <= '0;
        end else begin
            tag_vld[0]  <= push_rd;
            tag_port[0] <= take1;
            for (int i = 1; i < LAT; i++) begin
                tag_vld[i]  <= tag_vld[i-1];
                tag_port[i] <= tag_port[i-1];
            end
        end
    end

    assign rvalid0 = ~rst & tag_vld[LAT-1] & ~tag_port[LAT-1];
    assign rvalid1 = ~rst & tag_vld[LAT-1] & tag_port[LAT-1];
    assign rdata0  = rvalid0 ? d_fabric_out : 32'h0;
    assign rdata1  = rvalid1 ? d_fabric_out : 32'h0;
    assign out_reg = (OUT_REG != 0);

endmodule

// File: doc/sram_arb.md
# sram_arb

Two-requester arbiter and read-return sequencer in front of `sram_ifc`. Each requester presents one SRAM access (read or write, 14-bit address, 3-bit width conf) under a valid/ready handshake. The block issues at most one access per cycle to `sram_ifc` using round-robin arbitration. It tracks in-flight reads through the fixed `sram_ifc`/SRAM pipeline and steers returned data back to the requester that issued it, with an `rvalid` strobe.

## Interface

Parameters:
- `OUT_REG`, default 0: value driven on `sram_ifc.out_reg`; adds one cycle of read latency when 1.
- `BASE_LAT`, default 3: cycles from the grant edge to read data valid on `d_fabric_out` with `OUT_REG=0`.
- `FIXED_PRIO`, default 0: 1 means port 0 always wins; 0 means round-robin.

Ports:
- `clk` in 1: single clock, shared with `sram_ifc`.
- `rst` in 1: synchronous, active-high reset.
- `req0` / `req1` in 1: request valid. Must be held with stable fields until granted.
- `we0` / `we1` in 1: 1 = write, 0 = read.
- `addr0` / `addr1` in 14: {subaddr[13:9], baseaddr[8:0]}.
- `conf0` / `conf1` in 3: access width conf, passed through unchanged.
- `wdata0` / `wdata1` in 32: write data.
- `gnt0` / `gnt1` out 1: combinational ready. The handshake completes at the rising edge where `req & gnt` is high.
- `rvalid0` / `rvalid1` out 1: one-cycle strobe marking the read return.
- `rdata0` / `rdata1` out 32: equal to `d_fabric_out` while the matching `rvalid` is high; 0 otherwise.
- `csb` out 1: active-low chip select to `sram_ifc`. Registered.
- `web` out 1: active-low write enable to `sram_ifc`. Registered.
- `addr` out 14: address to `sram_ifc`. Registered.
- `conf` out 3: conf to `sram_ifc`. Registered.
- `d_fabric_in` out 32: write data to `sram_ifc`. Registered.
- `out_reg` out 1: tied to `OUT_REG`.
- `d_fabric_out` in 32: read data from `sram_ifc`.

## Operation

Arbitration:
- Grant is combinational from `req0`, `req1`, `rr_ptr` and `rst`. It never grants both ports in one cycle. `gnt0 = gnt1 = 0` while `rst` is high.
- Round-robin rule:
  - Only one port requesting: that port is granted, including every cycle back-to-back.
  - Both ports requesting: the port indicated by `rr_ptr` is granted.
  - After every grant, `rr_ptr` moves to the other port.
  - `rr_ptr` resets to port 0.
- `FIXED_PRIO=1`: port 0 is granted whenever `req0` is high; `rr_ptr` is ignored.
- `gnt` may be high while `req` is low. This has no effect.

Issue stage (registered):
- On a granted edge, load the winner's fields:
  - `csb <= 0`
  - `web <= ~we`
  - `addr`, `conf`, `d_fabric_in` from the winner.
- With no grant: `csb <= 1`, `web <= 1`. The other fields hold their values.

Read tracking:
- A tag shift register of depth `LAT = BASE_LAT + OUT_REG` carries {valid, port}.
- Entry is pushed at every grant edge; valid = 1 only for a granted read.
- When a tag reaches stage `LAT`, the block drives `rvalid[port] = 1` and `rdata[port] = d_fabric_out` for that one cycle.
- Writes never produce `rvalid`.
- Accesses complete in issue order. No hazard logic is required: the SRAM serialises accesses, and a read issued after a write to the same address returns the new data.

Reset:
- All outputs take these values while in reset and in the first cycle after reset:
  - `csb = 1`, `web = 1`
  - `addr = 0`, `conf = 0`, `d_fabric_in = 0`
  - `rvalid0/1 = 0`, `rdata0/1 = 0`
  - `gnt0/1 = 0` while `rst` is high.
- Reset mid-operation clears every tag. Reads in flight when reset is asserted never produce `rvalid`, even if `sram_ifc` later drives data.

## Timing

- Grant edge E0: request fields appear on the `sram_ifc` inputs after E0.
- `sram_ifc` captures them at E1. The SRAM latches at E2.
- Read data is valid in the cycle after E(`LAT`-1). `rvalid` is high in the cycle following edge E0+`LAT`-1; the requester samples at edge E0+`LAT`.
- Throughput: one access per cycle. Any mix of reads and writes can be issued back-to-back with no bubbles.
- The request-to-grant path is combinational. All `sram_ifc`-facing outputs come straight from flops.
- `rvalid0` and `rvalid1` are never high in the same cycle.

## Test plan

- **Reset values:** hold `rst` for 3 cycles with `req0 = req1 = 1`. Required: `gnt = 0`, `csb = 1`, `web = 1`, all `rvalid = 0` throughout, and first grant to port 0 in the cycle after `rst` falls.
- **Contention, round-robin:** `req0` and `req1` both held for 6 cycles. Required: grants alternate 0,1,0,1,0,1 and `csb = 0` for 6 consecutive cycles.
- **Write then read, `OUT_REG=0`:** port 0 writes `0xDEADBEEF` to addr `0x0012` with conf 0, then reads the same address on the next cycle. Required: `rvalid0` exactly 3 cycles after the read grant edge, `rdata0 = 0xDEADBEEF`, `rvalid1` stays 0.
- **`OUT_REG=1`:** the same sequence. Required: `rvalid0` 4 cycles after the read grant edge and `out_reg = 1`.
- **Interleaved reads:** back-to-back reads with port 0 to `0x0001` and port 1 to `0x0002`, holding distinct preloaded words `0x11111111` and `0x22222222`. Required: return strobes in consecutive cycles, each data word routed to the correct port, no overlap.
- **Reset mid-flight:** assert `rst` 1 cycle after a read grant. Required: no `rvalid` for that read, and `csb = 1` in the cycle after the reset edge.
